uart_stream_ctrl: RTL and testbench

- Byte-stream peer of the UART: consumes its received-byte stream and drives its transmit-byte stream.
- Packs an incoming picture (little-endian bytes) into 32-bit words and writes them to shared memory, then starts the accelerator.
- After the accelerator signals finish, reads the result region and streams it back to the PC byte by byte.
- Sits between the UART and the memory/accelerator in the top level.

---
 rtl/uart_stream_ctrl_pkg.sv | 28 ++
 rtl/uart_stream_ctrl_if.sv | 36 +++
 rtl/uart_stream_ctrl_serializer.sv | 54 +++++
 rtl/uart_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_stream_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// uart_stream_pkg : shared state encoding, byte-index type and picture sizes
// Rev 1.0
// ============================================================================
package uart_stream_pkg;

  localparam int DEF_COLS  = 352;
  localparam int DEF_ROWS  = 288;
  localparam int DEF_WORDS = DEF_COLS * DEF_ROWS / 4;

  localparam int IDX_W = 2;
  typedef logic [IDX_W-1:0] idx_t;

  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_RX       = 3'd0;
  localparam logic [2:0] ST_WRITE    = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_WAIT_ACC = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;
  localparam logic [2:0] ST_LATCH    = 3'd5;
  localparam logic [2:0] ST_SEND     = 3'd6;
`ifdef UART_STREAM_CSUM_EN
  localparam logic [2:0] ST_CSUM     = 3'd7;
`endif

endpackage
`default_nettype wire

// File: rtl/uart_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// uart_stream_ctrl_if : UART byte streams, memory port and accelerator strobes
// Rev 1.0
// ============================================================================
interface uart_stream_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        data_stream_out;
  logic              data_stream_out_stb;
  logic [7:0]        data_stream_in;
  logic              data_stream_in_stb;
  logic              data_stream_in_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              acc_start;
  logic              acc_finish;
  logic              frame_done;
  logic              overrun;

  modport master (
    input  data_stream_out, data_stream_out_stb, data_stream_in_ack, mem_rdata, acc_finish,
    output data_stream_in, data_stream_in_stb, mem_en, mem_we, mem_addr, mem_wdata,
           acc_start, frame_done, overrun
  );

  modport slave (
    output data_stream_out, data_stream_out_stb, data_stream_in_ack, mem_rdata, acc_finish,
    input  data_stream_in, data_stream_in_stb, mem_en, mem_we, mem_addr, mem_wdata,
           acc_start, frame_done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_stream_ctrl_serializer.sv
`default_nettype none
// ============================================================================
// stream_byte_serializer : sends bytes 0..last_idx of a loaded word, stb/ack
// Rev 1.0
// ============================================================================
module stream_byte_serializer
  import uart_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word,
  input  idx_t        last_idx,
  input  logic        ack,
  output logic [7:0]  data,
  output logic        stb,
  output logic        last
);
  logic [31:0] word_q;
  idx_t        idx;
  idx_t        last_q;
  logic        active;
  logic        byte_ack;

  assign byte_ack = stb && ack;
  assign last     = byte_ack && (idx == last_q);
  assign data     = active ? word_q[{idx, 3'b000} +: 8] : 8'h00;

  // stb falls for the cycle after every ack, then the next byte is presented
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      idx    <= '0;
      last_q <= '0;
      active <= 1'b0;
      stb    <= 1'b0;
    end else if (load) begin
      word_q <= word;
      idx    <= '0;
      last_q <= last_idx;
      active <= 1'b1;
      stb    <= 1'b1;
    end else if (active) begin
      if (byte_ack) begin
        stb <= 1'b0;
        if (idx == last_q) active <= 1'b0;
        else               idx    <= idx + 1'b1;
      end else begin
        stb <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_stream_ctrl.sv
`default_nettype none
// ============================================================================
// uart_stream_ctrl : UART picture in -> memory -> accelerator -> UART result out
// Optional trailing XOR checksum byte: define UART_STREAM_CSUM_EN. Rev 1.0
// ============================================================================
module uart_stream_ctrl
  import uart_stream_pkg::*;
#(
  parameter int P_WORDS    = DEF_WORDS,
  parameter int P_OUT_BASE = DEF_WORDS,
  parameter int P_ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_stream_ctrl_if.master  bus
);
  localparam logic [P_ADDR_W-1:0] LAST_WORD = P_ADDR_W'(P_WORDS - 1);
  localparam logic [P_ADDR_W-1:0] OUT_BASE  = P_ADDR_W'(P_OUT_BASE);

  state_t              state;
  logic [P_ADDR_W-1:0] word_cnt;
  idx_t                rx_idx;
  logic [31:0]         word_buf;
  logic                frame_done_q;
  logic                overrun_q;

  logic                ser_load;
  logic [31:0]         ser_word;
  idx_t                ser_last_idx;
  logic [7:0]          ser_data;
  logic                ser_stb;
  logic                ser_last;
  logic                rx_byte;

`ifdef UART_STREAM_CSUM_EN
  logic [7:0]          csum;
  logic                csum_pend;
`endif

  assign rx_byte = bus.data_stream_out_stb && (state == ST_RX || state == ST_WRITE);

  always_comb begin
    ser_load     = (state == ST_LATCH);
    ser_word     = bus.mem_rdata;
    ser_last_idx = '1;
`ifdef UART_STREAM_CSUM_EN
    if (state == ST_CSUM && csum_pend) begin
      ser_load     = 1'b1;
      ser_word     = {24'h0, csum};
      ser_last_idx = '0;
    end
`endif
  end

  stream_byte_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .word     (ser_word),
    .last_idx (ser_last_idx),
    .ack      (bus.data_stream_in_ack),
    .data     (ser_data),
    .stb      (ser_stb),
    .last     (ser_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_RX;
      word_cnt     <= '0;
      rx_idx       <= '0;
      word_buf     <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.data_stream_out_stb && !rx_byte) overrun_q <= 1'b1;
      // a byte landing in WRITE is byte 0 of the next word (rx_idx is already 0)
      if (rx_byte) begin
        word_buf[{rx_idx, 3'b000} +: 8] <= bus.data_stream_out;
        rx_idx                          <= rx_idx + 1'b1;
      end
      case (state)
        ST_RX:       if (rx_byte && rx_idx == '1) state <= ST_WRITE;
        ST_WRITE: begin
          if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            state    <= ST_START;
          end else begin
            word_cnt <= word_cnt + 1'b1;
            state    <= ST_RX;
          end
        end
        ST_START:    state <= ST_WAIT_ACC;
        ST_WAIT_ACC: if (bus.acc_finish) state <= ST_READ;
        ST_READ:     state <= ST_LATCH;
        ST_LATCH:    state <= ST_SEND;
        ST_SEND: begin
          if (ser_last) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              rx_idx   <= '0;
`ifdef UART_STREAM_CSUM_EN
              state    <= ST_CSUM;
`else
              frame_done_q <= 1'b1;
              state        <= ST_RX;
`endif
            end else begin
              word_cnt <= word_cnt + 1'b1;
              state    <= ST_READ;
            end
          end
        end
`ifdef UART_STREAM_CSUM_EN
        ST_CSUM: begin
          if (ser_last) begin
            frame_done_q <= 1'b1;
            state        <= ST_RX;
          end
        end
`endif
        default:     state <= ST_RX;
      endcase
    end
  end

`ifdef UART_STREAM_CSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum      <= 8'h00;
      csum_pend <= 1'b0;
    end else begin
      if (state == ST_SEND && ser_stb && bus.data_stream_in_ack) csum <= csum ^ ser_data;
      if (state == ST_CSUM && ser_last) csum <= 8'h00;
      if (state == ST_SEND && ser_last && word_cnt == LAST_WORD) csum_pend <= 1'b1;
      else if (state == ST_CSUM)                                 csum_pend <= 1'b0;
    end
  end
`endif

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == ST_WRITE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = word_cnt;
      bus.mem_wdata = word_buf;
    end else if (state == ST_READ) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = OUT_BASE + word_cnt;
    end
  end

  assign bus.acc_start          = (state == ST_START);
  assign bus.data_stream_in     = ser_data;
  assign bus.data_stream_in_stb = ser_stb;
  assign bus.frame_done         = frame_done_q;
  assign bus.overrun            = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_stream_ctrl : directed table-driven bench for uart_stream_ctrl
// Rev 1.0
// ============================================================================
module tb_uart_stream_ctrl;
  localparam int WORDS = 2;
  localparam int OBASE = 2;
  localparam int AW    = 16;

  typedef struct packed {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] addr;
    logic [31:0] word;
  } rx_vec_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] preload;
    logic [7:0]  e0, e1, e2, e3;
  } rb_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_stream_ctrl_if #(.ADDR_W(AW)) bus ();

  uart_stream_ctrl #(.P_WORDS(WORDS), .P_OUT_BASE(OBASE), .P_ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]   mem [0:15];
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr_q [$];
  logic [31:0]   wr_data_q [$];
  int start_cnt = 0, start_cyc = 0, fd_cnt = 0, fd_cyc = 0;

  always @(negedge clk) begin
    rd_pend = bus.mem_en && !bus.mem_we;
    rd_addr = bus.mem_addr;
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[3:0]] = bus.mem_wdata;
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
    if (bus.acc_start)  begin start_cnt++; start_cyc = cyc; end
    if (bus.frame_done) begin fd_cnt++;    fd_cyc    = cyc; end
  end

  always @(posedge clk) if (rd_pend) bus.mem_rdata <= mem[rd_addr[3:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_mem_en"},    32'(bus.mem_en), 0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_tx_data"},   32'(bus.data_stream_in), 0);
    chk({tag, "_tx_stb"},    32'(bus.data_stream_in_stb), 0);
    chk({tag, "_acc_start"}, 32'(bus.acc_start), 0);
    chk({tag, "_frame_done"},32'(bus.frame_done), 0);
    chk({tag, "_overrun"},   32'(bus.overrun), 0);
  endtask

  int last_stb_cyc = 0;
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.data_stream_out     = b;
    bus.data_stream_out_stb = 1'b1;
    last_stb_cyc            = cyc;
    @(negedge clk);
    bus.data_stream_out_stb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  rx_vec_t    rx_tab [2];
  rb_vec_t    rb_tab [2];
  logic [7:0] exp_q [$];

  initial begin
    int fin_cyc, ack_cyc, n, bad;
    logic [7:0] x;

    rx_tab[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 16'd0, 32'h44332211};
    rx_tab[1] = '{8'h55, 8'h66, 8'h77, 8'h88, 16'd1, 32'h88776655};
    rb_tab[0] = '{16'd2, 32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    rb_tab[1] = '{16'd3, 32'h01020304, 8'h04, 8'h03, 8'h02, 8'h01};

    bus.data_stream_out     = 8'h00;
    bus.data_stream_out_stb = 1'b0;
    bus.data_stream_in_ack  = 1'b1;
    bus.acc_finish          = 1'b0;
    bus.mem_rdata           = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("ack_ignored_stb", 32'(bus.data_stream_in_stb), 0);

    // receive packing
    for (int v = 0; v < 2; v++) begin
      send_byte(rx_tab[v].b0);
      send_byte(rx_tab[v].b1);
      send_byte(rx_tab[v].b2);
      send_byte(rx_tab[v].b3);
    end
    repeat (4) @(negedge clk);
    chk("wr_count", 32'(wr_addr_q.size()), 2);
    for (int v = 0; v < 2; v++) begin
      if (wr_addr_q.size() > v) begin
        chk($sformatf("wr_addr%0d", v), 32'(wr_addr_q[v]), 32'(rx_tab[v].addr));
        chk($sformatf("wr_data%0d", v), wr_data_q[v], rx_tab[v].word);
      end
    end
    chk("acc_start_count", 32'(start_cnt), 1);
    chk("acc_start_latency", 32'(start_cyc - last_stb_cyc), 2);
    chk("overrun_clear", 32'(bus.overrun), 0);

    // in WAIT_ACC: spurious acks and a stray byte
    for (int v = 0; v < 2; v++) mem[rb_tab[v].addr[3:0]] = rb_tab[v].preload;
    @(negedge clk) bus.data_stream_in_ack = 1'b0;
    @(negedge clk) bus.data_stream_in_ack = 1'b1;
    @(negedge clk) bus.data_stream_in_ack = 1'b0;
    chk("wait_tx_stb", 32'(bus.data_stream_in_stb), 0);
    send_byte(8'h99);
    chk("overrun_set", 32'(bus.overrun), 1);
    chk("overrun_no_write", 32'(wr_addr_q.size()), 2);
    chk("wait_no_mem", 32'(bus.mem_en), 0);

    for (int v = 0; v < 2; v++) begin
      exp_q.push_back(rb_tab[v].e0);
      exp_q.push_back(rb_tab[v].e1);
      exp_q.push_back(rb_tab[v].e2);
      exp_q.push_back(rb_tab[v].e3);
    end
`ifdef UART_STREAM_CSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif

    @(negedge clk);
    bus.acc_finish = 1'b1;
    fin_cyc        = cyc;
    @(negedge clk);
    bus.acc_finish = 1'b0;

    ack_cyc = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n = 0;
      while (!bus.data_stream_in_stb && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL tx_stb_timeout byte %0d: actual=no stb required=stb", i);
        break;
      end
      if (i == 0) chk("first_tx_latency", 32'(cyc - fin_cyc), 3);
      if (i % 4 != 0 && i < 8) chk($sformatf("gap%0d", i), 32'(n), 1);
      chk($sformatf("tx_byte%0d", i), 32'(bus.data_stream_in), 32'(exp_q[i]));
      if (i == 0) begin
        bad = 0;
        repeat (1000) begin
          @(negedge clk);
          if (bus.data_stream_in !== exp_q[0] || bus.data_stream_in_stb !== 1'b1) bad++;
        end
        chk("hold_stable", 32'(bad), 0);
      end
      bus.data_stream_in_ack = 1'b1;
      ack_cyc                = cyc;
      @(negedge clk);
      bus.data_stream_in_ack = 1'b0;
      chk($sformatf("stb_drop%0d", i), 32'(bus.data_stream_in_stb), 0);
    end
    repeat (5) @(negedge clk);
    chk("frame_done_count", 32'(fd_cnt), 1);
    chk("frame_done_latency", 32'(fd_cyc - ack_cyc), 1);
    chk("acc_start_once", 32'(start_cnt), 1);
    chk("overrun_sticky", 32'(bus.overrun), 1);

    // asynchronous reset mid-word, then a fresh word
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_idle("async");
    @(negedge clk);
    rst = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    repeat (3) @(negedge clk);
    chk("post_reset_wr_count", 32'(wr_addr_q.size()), 1);
    if (wr_addr_q.size() > 0) begin
      chk("post_reset_addr", 32'(wr_addr_q[0]), 0);
      chk("post_reset_data", wr_data_q[0], 32'hEFBEADDE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
